// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: serial register-access responder between uart_rx and uart_tx.
// Parses A5/addr/data write frames and 5A/addr read frames, runs them against an
// internal 8-bit register file, and queues one response per frame to uart_tx
// through a small FIFO.
// Optional build macro UART_RSP_CHECKSUM_EN: every frame carries a trailing XOR
// checksum byte, and each read answers with two bytes (data, then its checksum).
//
// Parser states
//   state  | meaning
//   S_CMD  | waiting for a command byte (A5 write, 5A read, anything else is NAKed)
//   S_ADDR | waiting for the address byte
//   S_DATA | waiting for the write data byte
//   S_CSUM | waiting for the checksum byte (checksum build only)
//   S_EXEC | single cycle: apply the write or read and queue the response
//
// TX sequencer states
//   state  | meaning
//   T_IDLE | a byte can be launched when the FIFO has data and uart_tx is not busy
//   T_WAIT | one byte outstanding; waiting for the rising edge of i_Tx_Done

module uart_cmd_responder #(
    parameter int REG_COUNT    = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Rx_DV,
    input  logic [7:0]             i_Rx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    output logic [8*REG_COUNT-1:0] o_Regs,
    output logic                   o_Frame_Abort,
    output logic                   o_Overflow
);

    localparam logic [7:0] CMD_WR  = 8'hA5;
    localparam logic [7:0] CMD_RD  = 8'h5A;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC} p_state_t;
    typedef enum logic {T_IDLE, T_WAIT} t_state_t;

`ifdef UART_RSP_CHECKSUM_EN
    localparam p_state_t S_TAIL = S_CSUM;
`else
    localparam p_state_t S_TAIL = S_EXEC;
`endif

    p_state_t p_state, p_nxt;
    t_state_t t_state, t_nxt;

    logic                   rx_dv_q;
    logic                   rx_stb;
    logic                   pend_vld;
    logic [7:0]             pend_byte;
    logic                   stb;
    logic [7:0]             byte_in;

    logic                   is_wr_q;
    logic [7:0]             addr_q;
    logic [7:0]             data_q;
    logic [TW-1:0]          tmr;
    logic                   timed;

    logic                   lat_cmd, lat_addr, lat_data, do_exec, abort, nak_cmd;
    logic                   addr_ok, csum_bad, frame_bad;
    logic [7:0]             rd_data;
    logic [8*REG_COUNT-1:0] regs_q;

    logic [1:0]             push_n;
    logic [7:0]             push_b0, push_b1;
    logic                   push_ok;
    logic                   pop;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr, wr_ptr_p1;
    logic [CW-1:0]          count, free;

    logic                   tx_done_q;
    logic                   done_rise;

    // Byte strobes; a byte arriving during S_EXEC is parked and replayed in S_CMD.
    assign rx_stb    = i_Rx_DV & ~rx_dv_q;
    assign stb       = rx_stb | pend_vld;
    assign byte_in   = pend_vld ? pend_byte : i_Rx_Byte;
    assign timed     = (p_state == S_ADDR) || (p_state == S_DATA) || (p_state == S_CSUM);
    assign addr_ok   = addr_q < 8'(REG_COUNT);
    assign frame_bad = !addr_ok || csum_bad;
    assign done_rise = i_Tx_Done & ~tx_done_q;
    assign o_Regs    = regs_q;

    // Read mux over the register file.
    always_comb begin
        rd_data = 8'h00;
        for (int n = 0; n < REG_COUNT; n++) begin
            if (addr_q == 8'(n)) rd_data = regs_q[8*n +: 8];
        end
    end

    // Parser state register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) p_state <= S_CMD;
        else         p_state <= p_nxt;
    end

    // Parser next state and byte-latch controls.
    always_comb begin
        p_nxt    = p_state;
        lat_cmd  = 1'b0;
        lat_addr = 1'b0;
        lat_data = 1'b0;
        do_exec  = 1'b0;
        abort    = 1'b0;
        nak_cmd  = 1'b0;
        case (p_state)
            S_CMD: begin
                if (stb) begin
                    if (byte_in == CMD_WR || byte_in == CMD_RD) begin
                        lat_cmd = 1'b1;
                        p_nxt   = S_ADDR;
                    end else begin
                        nak_cmd = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (stb) begin
                    lat_addr = 1'b1;
                    p_nxt    = is_wr_q ? S_DATA : S_TAIL;
                end else if (tmr == '0) begin
                    abort = 1'b1;
                    p_nxt = S_CMD;
                end
            end
            S_DATA: begin
                if (stb) begin
                    lat_data = 1'b1;
                    p_nxt    = S_TAIL;
                end else if (tmr == '0) begin
                    abort = 1'b1;
                    p_nxt = S_CMD;
                end
            end
            S_CSUM: begin
                if (stb) begin
                    p_nxt = S_EXEC;
                end else if (tmr == '0) begin
                    abort = 1'b1;
                    p_nxt = S_CMD;
                end
            end
            S_EXEC: begin
                do_exec = 1'b1;
                p_nxt   = S_CMD;
            end
            default: p_nxt = S_CMD;
        endcase
    end

    // Response selection for the current cycle.
    always_comb begin
        push_n  = 2'd0;
        push_b0 = 8'h00;
        push_b1 = 8'h00;
        if (nak_cmd) begin
            push_n  = 2'd1;
            push_b0 = RSP_NAK;
        end else if (do_exec) begin
            if (frame_bad) begin
                push_n  = 2'd1;
                push_b0 = RSP_NAK;
            end else if (is_wr_q) begin
                push_n  = 2'd1;
                push_b0 = RSP_ACK;
            end else begin
`ifdef UART_RSP_CHECKSUM_EN
                push_n  = 2'd2;
                push_b0 = rd_data;
                push_b1 = rd_data;
`else
                push_n  = 2'd1;
                push_b0 = rd_data;
`endif
            end
        end
    end

    // Edge detect, frame fields, idle timer, abort pulse and register writes.
    // rx_dv_q resets high so a DV held across reset release is not taken as a byte.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_dv_q       <= 1'b1;
            pend_vld      <= 1'b0;
            pend_byte     <= 8'h00;
            is_wr_q       <= 1'b0;
            addr_q        <= 8'h00;
            data_q        <= 8'h00;
            tmr           <= TMR_LOAD;
            o_Frame_Abort <= 1'b0;
            regs_q        <= '0;
        end else begin
            rx_dv_q       <= i_Rx_DV;
            o_Frame_Abort <= abort;
            if (p_state == S_EXEC && rx_stb) begin
                pend_vld  <= 1'b1;
                pend_byte <= i_Rx_Byte;
            end else if (p_state == S_CMD) begin
                pend_vld  <= 1'b0;
            end
            if (lat_cmd)  is_wr_q <= (byte_in == CMD_WR);
            if (lat_addr) addr_q  <= byte_in;
            if (lat_data) data_q  <= byte_in;
            if (timed && !stb && tmr != '0) tmr <= tmr - TW'(1);
            else                            tmr <= TMR_LOAD;
            if (do_exec && is_wr_q && !frame_bad) begin
                for (int n = 0; n < REG_COUNT; n++) begin
                    if (addr_q == 8'(n)) regs_q[8*n +: 8] <= data_q;
                end
            end
        end
    end

`ifdef UART_RSP_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       csum_bad_q;

    // Running XOR of the frame bytes and the verdict on the trailing checksum.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            xor_q      <= 8'h00;
            csum_bad_q <= 1'b0;
        end else begin
            if (lat_cmd)                    xor_q <= byte_in;
            else if (lat_addr || lat_data)  xor_q <= xor_q ^ byte_in;
            if (p_state == S_CSUM && stb)   csum_bad_q <= (byte_in != xor_q);
        end
    end

    assign csum_bad = csum_bad_q;
`else
    assign csum_bad = 1'b0;
`endif

    // FIFO bookkeeping: a response is accepted whole or not at all.
    always_comb begin
        free      = CW'(FIFO_DEPTH) - count;
        push_ok   = (push_n != 2'd0) && (CW'(push_n) <= free);
        wr_ptr_p1 = wr_ptr + PW'(1);
    end

    // FIFO storage.
    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_b0;
            if (push_n == 2'd2) mem[wr_ptr_p1] <= push_b1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(push_n);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + (push_ok ? CW'(push_n) : CW'(0)) - CW'(pop);
            if (push_n != 2'd0 && !push_ok) o_Overflow <= 1'b1;
        end
    end

    // TX sequencer state register and launch registers.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            t_state   <= T_IDLE;
            tx_done_q <= 1'b0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
        end else begin
            t_state   <= t_nxt;
            tx_done_q <= i_Tx_Done;
            o_Tx_DV   <= pop;
            if (pop) o_Tx_Byte <= mem[rd_ptr];
        end
    end

    // TX sequencer next state: one byte in flight at a time.
    always_comb begin
        t_nxt = t_state;
        pop   = 1'b0;
        case (t_state)
            T_IDLE: begin
                if (count != '0 && !i_Tx_Active) begin
                    pop   = 1'b1;
                    t_nxt = T_WAIT;
                end
            end
            T_WAIT: begin
                if (done_rise) t_nxt = T_IDLE;
            end
            default: t_nxt = T_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: directed frames, a held-off transmitter to fill
// the response FIFO, an idle-timeout abort, reset mid-frame and a random phase,
// all checked against a frame-level model of the register file and responses.
// Works for both builds (with or without UART_RSP_CHECKSUM_EN).

module tb_uart_cmd_responder;

    localparam int REG_COUNT    = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int IDLE_TIMEOUT = 64;

    logic                   clk;
    logic                   rst;
    logic                   rx_dv;
    logic [7:0]             rx_byte;
    logic                   tx_active;
    logic                   tx_done;
    logic                   tx_dv;
    logic [7:0]             tx_byte;
    logic [8*REG_COUNT-1:0] regs;
    logic                   frame_abort;
    logic                   overflow;

    uart_cmd_responder #(
        .REG_COUNT   (REG_COUNT),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .i_Tx_Active  (tx_active),
        .i_Tx_Done    (tx_done),
        .o_Tx_DV      (tx_dv),
        .o_Tx_Byte    (tx_byte),
        .o_Regs       (regs),
        .o_Frame_Abort(frame_abort),
        .o_Overflow   (overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_regs [REG_COUNT];
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    bit         tx_hold = 1'b0;
    int         held = 0;
    bit         exp_ovf = 1'b0;
    int         dv_count = 0;
    int         stab_err = 0;
    int         busy_dv_err = 0;
    logic [7:0] cap;

    int         since_dv = 0;
    logic       dv_prev = 1'b1;
    int         abort_cnt = 0;
    int         abort_at = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycles since the last rising edge of rx_dv, and abort pulse log.
    always @(posedge clk) begin
        if (rx_dv && !dv_prev) since_dv = 0;
        else                   since_dv = since_dv + 1;
        dv_prev = rx_dv;
    end

    always @(negedge clk) begin
        if (frame_abort === 1'b1) begin
            abort_cnt = abort_cnt + 1;
            abort_at  = since_dv;
        end
    end

    // uart_tx stand-in: accepts a byte on DV, stays busy, then pulses Done.
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                cap = tx_byte;
                got.push_back(cap);
                dv_count  = dv_count + 1;
                tx_active = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (tx_byte !== cap) stab_err = stab_err + 1;
                    if (tx_dv !== 1'b0)  busy_dv_err = busy_dv_err + 1;
                end
                tx_done = 1'b1;
                @(negedge clk);
                if (tx_byte !== cap) stab_err = stab_err + 1;
                tx_done   = 1'b0;
                tx_active = tx_hold;
            end else begin
                tx_active = tx_hold;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < REG_COUNT; i++)
            chk(tag, 32'(regs[8*i +: 8]), 32'(ref_regs[i]));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_dv   = 1'b1;
        repeat (2) @(negedge clk);
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Expected response bytes; while uart_tx is held off the FIFO capacity applies.
    task automatic model_push(input logic [7:0] b, input int n);
        if (tx_hold && held + n > FIFO_DEPTH) begin
            exp_ovf = 1'b1;
        end else begin
            if (tx_hold) held = held + n;
            for (int i = 0; i < n; i++) exp_q.push_back(b);
        end
    endtask

    // kind: 0 write, 1 read, 2 unknown command (data holds the command byte).
    task automatic model_frame(input int kind, input logic [7:0] addr,
                               input logic [7:0] data, input bit bad_csum);
        int rd_n;
`ifdef UART_RSP_CHECKSUM_EN
        rd_n = 2;
`else
        rd_n = 1;
`endif
        if (kind == 2)                             model_push(8'h15, 1);
        else if (bad_csum || addr >= REG_COUNT)    model_push(8'h15, 1);
        else if (kind == 0) begin
            ref_regs[addr] = data;
            model_push(8'h06, 1);
        end else                                   model_push(ref_regs[addr], rd_n);
    endtask

    task automatic do_frame(input int kind, input logic [7:0] addr,
                            input logic [7:0] data, input bit bad_csum);
        logic [7:0] x;
        if (kind == 2) begin
            send_byte(data);
        end else begin
            x = (kind == 0) ? 8'hA5 : 8'h5A;
            send_byte(x);
            send_byte(addr);
            x = x ^ addr;
            if (kind == 0) begin
                send_byte(data);
                x = x ^ data;
            end
`ifdef UART_RSP_CHECKSUM_EN
            send_byte(bad_csum ? ~x : x);
`endif
        end
        model_frame(kind, addr, data, bad_csum);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int         dv0;
        int         kind;
        logic [7:0] a, d, last;

        for (int i = 0; i < REG_COUNT; i++) ref_regs[i] = 8'h00;

        // Reset with DV already high: the held DV must not count as a byte.
        rst     = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = 8'h77;
        repeat (3) @(negedge clk);
        chk("rst_tx_dv",    32'(tx_dv),       32'h0);
        chk("rst_tx_byte",  32'(tx_byte),     32'h0);
        chk("rst_regs",     32'(regs),        32'h0);
        chk("rst_abort",    32'(frame_abort), 32'h0);
        chk("rst_overflow", 32'(overflow),    32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);

        // Test 1: write 3C to reg2, with the register update two edges after the last strobe.
        send_byte(8'hA5);
        send_byte(8'h02);
`ifdef UART_RSP_CHECKSUM_EN
        send_byte(8'h3C);
        last = 8'hA5 ^ 8'h02 ^ 8'h3C;
`else
        last = 8'h3C;
`endif
        @(negedge clk);
        rx_byte = last;
        rx_dv   = 1'b1;
        @(posedge clk); #1;
        chk("t1_reg2_edge1", 32'(regs[23:16]), 32'h00);
        @(posedge clk); #1;
        chk("t1_reg2_edge2", 32'(regs[23:16]), 32'h3C);
        @(negedge clk);
        rx_dv = 1'b0;
        model_frame(0, 8'h02, 8'h3C, 1'b0);
        drain("t1");
        chk_regs("t1_regs");

        // Test 2: read back, and a read outside the register file.
        do_frame(1, 8'h02, 8'h00, 1'b0);
        do_frame(1, 8'h07, 8'h00, 1'b0);
        drain("t2");
        chk_regs("t2_regs");

        // Test 3: unknown command byte, then a normal write.
        do_frame(2, 8'h00, 8'h77, 1'b0);
        do_frame(0, 8'h00, 8'hFF, 1'b0);
        drain("t3");
        chk_regs("t3_regs");

        // Test 4: partial frame times out, then the parser accepts a new frame.
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (IDLE_TIMEOUT + 20) @(negedge clk);
        chk("t4_abort_cnt", abort_cnt, 1);
        chk("t4_abort_window", 32'((abort_at >= IDLE_TIMEOUT) && (abort_at <= IDLE_TIMEOUT + 2)), 32'h1);
        chk("t4_no_tx", got.size(), 0);
        do_frame(0, 8'h01, 8'h55, 1'b0);
        drain("t4");
        chk_regs("t4_regs");

        // Test 5: transmitter busy, five reads overfill the FIFO.
        chk("t5_ovf_before", 32'(overflow), 32'h0);
        tx_hold = 1'b1;
        held    = 0;
        repeat (2) @(negedge clk);
        dv0 = dv_count;
        for (int i = 0; i < 5; i++) do_frame(1, 8'($urandom_range(0, REG_COUNT - 1)), 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        chk("t5_ovf_after", 32'(overflow), 32'(exp_ovf));
        chk("t5_no_dv", dv_count, dv0);
        tx_hold = 1'b0;
        held    = 0;
        drain("t5");

`ifdef UART_RSP_CHECKSUM_EN
        // Test 6: good and bad checksums.
        do_frame(0, 8'h01, 8'h10, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h77);
        send_byte(8'h00);
        model_frame(0, 8'h01, 8'h77, 1'b1);
        drain("t6");
        chk_regs("t6_regs");
`endif

        // Reset mid-frame: partial frame and registers are lost.
        send_byte(8'hA5);
        send_byte(8'h02);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < REG_COUNT; i++) ref_regs[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk_regs("rst2_regs");
        chk("rst2_ovf", 32'(overflow), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_frame(0, 8'h03, 8'hC3, 1'b0);
        drain("rst2");
        chk_regs("rst2_after");

        // Random phase.
        for (int g = 0; g < 10; g++) begin
            for (int f = 0; f < 4; f++) begin
                kind = $urandom_range(0, 9);
                kind = (kind < 4) ? 0 : (kind < 8) ? 1 : 2;
                a = 8'($urandom_range(0, REG_COUNT + 1));
                d = 8'($urandom);
                if (kind == 2 && (d == 8'hA5 || d == 8'h5A)) d = 8'h00;
                do_frame(kind, a, d, 1'b0);
            end
            drain("rand");
            chk_regs("rand_regs");
        end

        chk("end_abort_total", abort_cnt, 1);
        chk("end_tx_stable", stab_err, 0);
        chk("end_one_outstanding", busy_dv_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
